// File: rtl/rect_flip_pkg.sv
// rect_flip_pkg: shared command types and corner/mask helpers for the rectangle flip engine.
package rect_flip_pkg;
  localparam int COORD_W = 8;
  localparam int MAX_BITS = 256;
  typedef enum logic [1:0] {OP_FLIP, OP_SET, OP_CLEAR, OP_QUERY} op_e;
  typedef struct packed {
    op_e               op;
    logic [COORD_W-1:0] r1;
    logic [COORD_W-1:0] r2;
    logic [COORD_W-1:0] c1;
    logic [COORD_W-1:0] c2;
  } cmd_t;
  function automatic int corner_index(int rows, int cols, int r, int c);
    return rows * cols - 1 - (r * cols + c);
  endfunction
  function automatic logic [MAX_BITS-1:0] rect_mask(int rows, int cols, int r1, int r2, int c1, int c2);
    logic [MAX_BITS-1:0] m;
    int idx [4];
    m = '0;
    idx[0] = corner_index(rows, cols, r1, c1);
    idx[1] = corner_index(rows, cols, r1, c2);
    idx[2] = corner_index(rows, cols, r2, c1);
    idx[3] = corner_index(rows, cols, r2, c2);
    for (int k = 0; k < 4; k++)
      if (idx[k] >= 0 && idx[k] < MAX_BITS) m[idx[k]] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/rect_flip_engine_fifo.sv
// rect_cmd_fifo: synchronous command queue exposing full, empty and the head entry.
module rect_cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= data_i;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/rect_flip_engine.sv
// rect_flip_engine: queued rectangle-corner flip/set/clear/query engine over a ROWS x COLS bit matrix.
module rect_flip_engine
  import rect_flip_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int RW = $clog2(ROWS) > 1 ? $clog2(ROWS) : 1,
  localparam int CW = $clog2(COLS) > 1 ? $clog2(COLS) : 1,
  localparam int N = ROWS * COLS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [N-1:0]  load_data,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_r1,
  input  logic [RW-1:0] cmd_r2,
  input  logic [CW-1:0] cmd_c1,
  input  logic [CW-1:0] cmd_c2,
  output logic          rsp_valid,
  output logic          rsp_hit,
  output logic          rsp_err,
  output logic [N-1:0]  m_out,
  output logic          busy,
  output logic [15:0]   flip_count
);
  cmd_t push_cmd, head;
  logic full, empty, pop, valid_cmd, hit;
  logic [N-1:0] mask, m_d, m_q;
  logic [15:0] fc_d, fc_q;
  logic rsp_valid_q, rsp_hit_q, rsp_err_q;
  assign cmd_ready = !full && !reset;
  assign pop = !empty && !load_valid;
  assign push_cmd = '{op: op_e'(cmd_op), r1: COORD_W'(cmd_r1), r2: COORD_W'(cmd_r2),
                      c1: COORD_W'(cmd_c1), c2: COORD_W'(cmd_c2)};
  rect_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(cmd_valid && cmd_ready), .pop_i(pop),
    .data_i(push_cmd), .data_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    valid_cmd = head.r1 < COORD_W'(ROWS) && head.r2 < COORD_W'(ROWS) && head.c1 < COORD_W'(COLS) &&
                head.c2 < COORD_W'(COLS) && head.r1 != head.r2 && head.c1 != head.c2;
    mask = valid_cmd ? N'(rect_mask(ROWS, COLS, int'(head.r1), int'(head.r2), int'(head.c1), int'(head.c2))) : '0;
    hit = valid_cmd && ((m_q & mask) == mask);
    m_d = load_valid ? load_data :
          !pop || !valid_cmd ? m_q :
          head.op == OP_FLIP ? m_q ^ mask :
          head.op == OP_SET ? m_q | mask :
          head.op == OP_CLEAR ? m_q & ~mask : m_q;
    fc_d = (pop && valid_cmd && head.op == OP_FLIP && fc_q != 16'hFFFF) ? fc_q + 16'd1 : fc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      fc_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      m_q <= m_d;
      fc_q <= fc_d;
      rsp_valid_q <= pop;
      rsp_hit_q <= pop && hit;
      rsp_err_q <= pop && !valid_cmd;
    end
  end
  assign m_out = m_q;
  assign flip_count = fc_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_err = rsp_err_q;
  assign busy = !empty;
endmodule

// File: tb/tb_rect_flip_engine.sv
// tb_rect_flip_engine: table-driven and scoreboarded checks of rect_flip_engine, plus a 5x3 build.
module tb_rect_flip_engine;
  logic clk = 1'b0;
  logic reset, load_valid, cmd_valid, cmd_ready, rsp_valid, rsp_hit, rsp_err, busy;
  logic [15:0] load_data, m_out, flip_count;
  logic [1:0] cmd_op, cmd_r1, cmd_r2, cmd_c1, cmd_c2;
  logic d2_cmd_valid, d2_cmd_ready, d2_rsp_valid, d2_rsp_hit, d2_rsp_err, d2_busy;
  logic [14:0] d2_m_out;
  logic [15:0] d2_flip_count;
  logic [1:0] d2_op, d2_c1, d2_c2;
  logic [2:0] d2_r1, d2_r2;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;

  rect_flip_engine dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1), .cmd_c2(cmd_c2),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .m_out(m_out), .busy(busy), .flip_count(flip_count)
  );
  rect_flip_engine #(.ROWS(5), .COLS(3)) dut2 (
    .clk(clk), .reset(reset), .load_valid(1'b0), .load_data(15'h0),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_op(d2_op),
    .cmd_r1(d2_r1), .cmd_r2(d2_r2), .cmd_c1(d2_c1), .cmd_c2(d2_c2),
    .rsp_valid(d2_rsp_valid), .rsp_hit(d2_rsp_hit), .rsp_err(d2_rsp_err),
    .m_out(d2_m_out), .busy(d2_busy), .flip_count(d2_flip_count)
  );

  typedef struct {
    logic ld; logic [15:0] ldata;
    logic [1:0] op, r1, r2, c1, c2;
    logic [15:0] em; logic eh, ee; logic [15:0] efc;
  } vec_t;
  typedef struct { logic [15:0] m; logic h, e; logic [15:0] fc; } exp_t;
  exp_t exp_q[$];
  vec_t tbl[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] m, input logic h, input logic e, input logic [15:0] fc);
    exp_t x;
    x.m = m; x.h = h; x.e = e; x.fc = fc;
    exp_q.push_back(x);
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d);
    int n;
    logic acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_r1 = a; cmd_r2 = b; cmd_c1 = c; cmd_c2 = d;
    n = 0;
    do begin
      acc = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    cmd_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic d2_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    int t;
    d2_cmd_valid = 1'b1; d2_op = op; d2_r1 = a; d2_r2 = b; d2_c1 = c; d2_c2 = d;
    chk("d2_ready", 16'(d2_cmd_ready), 16'h1);
    @(posedge clk); #1;
    d2_cmd_valid = 1'b0;
    t = 0;
    while (!d2_rsp_valid && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("d2_rsp_seen", 16'(d2_rsp_valid), 16'h1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_m", m_out, e.m);
        chk("rsp_hit", 16'(rsp_hit), 16'(e.h));
        chk("rsp_err", 16'(rsp_err), 16'(e.e));
        chk("flip_count", flip_count, e.fc);
      end
    end
  end

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 16'h5050, 1'b0, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 16'hFFFF, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 16'hFFFF, 1'b1, 1'b0, 16'd1};
    tbl[2] = '{1'b0, 16'h0000, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 16'hF5F5, 1'b1, 1'b0, 16'd1};
    tbl[3] = '{1'b0, 16'h0000, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 16'hF5F5, 1'b0, 1'b1, 16'd1};
    tbl[4] = '{1'b0, 16'h0000, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 16'hF5F5, 1'b0, 1'b0, 16'd1};
    tbl[5] = '{1'b0, 16'h0000, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 16'hFFFF, 1'b0, 1'b0, 16'd1};
    tbl[6] = '{1'b0, 16'h0000, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 16'h6FF6, 1'b1, 1'b0, 16'd2};
    tbl[7] = '{1'b1, 16'h0000, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 16'hCC00, 1'b0, 1'b0, 16'd2};
    tbl[8] = '{1'b0, 16'h0000, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 16'hCC00, 1'b0, 1'b1, 16'd2};
    tbl[9] = '{1'b0, 16'h0000, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 16'h0000, 1'b1, 1'b0, 16'd3};
    reset = 1'b1; load_valid = 1'b0; load_data = '0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_r1 = '0; cmd_r2 = '0; cmd_c1 = '0; cmd_c2 = '0;
    d2_cmd_valid = 1'b0; d2_op = '0; d2_r1 = '0; d2_r2 = '0; d2_c1 = '0; d2_c2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m", m_out, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_rsp_hit", 16'(rsp_hit), 16'h0);
    chk("rst_rsp_err", 16'(rsp_err), 16'h0);
    chk("rst_flip_count", flip_count, 16'h0);
    chk("rst_ready", 16'(cmd_ready), 16'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 16'(cmd_ready), 16'h1);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].ld) begin
        load_valid = 1'b1; load_data = tbl[i].ldata;
        @(posedge clk); #1;
        load_valid = 1'b0;
      end
      push_exp(tbl[i].em, tbl[i].eh, tbl[i].ee, tbl[i].efc);
      push(tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].c1, tbl[i].c2);
      wait_drain();
    end
    // Queue stalled by a held load: four accepts fill it, the fifth must wait.
    load_valid = 1'b1; load_data = 16'h0000;
    push_exp(16'hCC00, 1'b0, 1'b0, 16'd4); push(2'd0, 2'd0, 2'd1, 2'd0, 2'd1);
    push_exp(16'h6CA0, 1'b0, 1'b0, 16'd5); push(2'd0, 2'd0, 2'd2, 2'd0, 2'd2);
    push_exp(16'hECA0, 1'b0, 1'b0, 16'd5); push(2'd1, 2'd0, 2'd1, 2'd0, 2'd1);
    push_exp(16'hECA0, 1'b1, 1'b0, 16'd5); push(2'd3, 2'd0, 2'd1, 2'd0, 2'd1);
    chk("full_ready", 16'(cmd_ready), 16'h0);
    chk("full_busy", 16'(busy), 16'h1);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_r1 = 2'd0; cmd_r2 = 2'd1; cmd_c1 = 2'd0; cmd_c2 = 2'd1;
    repeat (2) begin @(posedge clk); #1; end
    chk("held_ready", 16'(cmd_ready), 16'h0);
    chk("stalled_m", m_out, 16'h0000);
    load_valid = 1'b0;
    push_exp(16'h20A0, 1'b1, 1'b0, 16'd5); push(2'd2, 2'd0, 2'd1, 2'd0, 2'd1);
    wait_drain();
    // Load arriving while a FLIP is queued takes priority; the FLIP sees the loaded image.
    push_exp(16'h823D, 1'b0, 1'b0, 16'd6);
    push(2'd0, 2'd0, 2'd3, 2'd0, 2'd3);
    load_valid = 1'b1; load_data = 16'h1234;
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("load_wins_m", m_out, 16'h1234);
    chk("load_wins_norsp", 16'(rsp_valid), 16'h0);
    wait_drain();
    // Reset with three commands queued discards them all.
    load_valid = 1'b1; load_data = 16'h0F0F;
    push(2'd0, 2'd0, 2'd1, 2'd0, 2'd1);
    push(2'd1, 2'd1, 2'd2, 2'd1, 2'd2);
    push(2'd0, 2'd2, 2'd3, 2'd2, 2'd3);
    chk("queued_busy", 16'(busy), 16'h1);
    reset = 1'b1; load_valid = 1'b0;
    #1;
    chk("ready_in_rst", 16'(cmd_ready), 16'h0);
    @(posedge clk); #1;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("midrst_m", m_out, 16'h0);
    chk("midrst_flip_count", flip_count, 16'h0);
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("postrst_busy", 16'(busy), 16'h0);
    // 5x3 instance: out-of-range row is rejected, a valid FLIP lands on bits 14,12,2,0.
    d2_cmd(2'd0, 3'd7, 3'd0, 2'd0, 2'd1);
    chk("d2_oor_err", 16'(d2_rsp_err), 16'h1);
    chk("d2_oor_m", 16'(d2_m_out), 16'h0);
    chk("d2_oor_fc", d2_flip_count, 16'h0);
    d2_cmd(2'd0, 3'd0, 3'd4, 2'd0, 2'd2);
    chk("d2_flip_err", 16'(d2_rsp_err), 16'h0);
    chk("d2_flip_m", 16'(d2_m_out), 16'h5005);
    chk("d2_flip_fc", d2_flip_count, 16'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
